vector_encoder: RTL
===================

Name: vector_encoder

Overview:
- Sequential 8-to-3 encoder; the counterpart to the team's combinational 3-to-8 decoder.
- Collects event bits on a `vector` input into a sticky pending register.
- Serves pending bits one at a time, presenting each bit's index on `digit` under a valid/ready handshake.
- Used wherever multiple one-cycle request or interrupt lines must be converted to a binary index for a single consumer.

Parameters:
- WIDTH, 8, number of request lines in `vector`.
- DW, 3, width of `digit`; must equal clog2(WIDTH).

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- vector, input, WIDTH, request bits; a bit high for one cycle posts one event.
- digit, output, DW, index of the bit currently offered.
- valid, output, 1, `digit` is offered to the consumer.
- ready, input, 1, consumer accepts `digit` when ready & valid at a clock edge.
- pending, output, WIDTH, registered pending-request mask.
- overflow, output, 1, sticky flag: an event was posted to a bit that was already pending.

Behaviour:
- Interface decision: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values (applied immediately on rst_n low, independent of clk):
  - digit=0, valid=0, pending=0, overflow=0, state=IDLE.
  - Round-robin pointer = WIDTH-1 (macro builds only).
- Pending update, every edge: pending <= (pending & ~clr) | vector.
  - clr = one-hot(digit) when ready & valid; otherwise 0.
  - If vector[i] is high in the same cycle that bit i is cleared, bit i stays set as a new event. No overflow is raised in that case.
- Overflow: set when vector[i] & pending[i] & ~clr[i] for any i. Cleared only by reset.
- Selection function sel(mask):
  - Fixed priority: lowest set index wins.
  - Exactly one index is chosen.
  - mask==0 yields no selection.
- State IDLE:
  - valid=0.
  - If registered pending!=0: digit <= sel(pending), valid <= 1, go to OFFER.
  - Latency: vector bit sampled at edge N; pending set after N; valid=1 with digit after N+1.
- State OFFER:
  - valid=1; digit held stable until the handshake.
  - On ready & valid, with rem = pending & ~one-hot(digit):
    - rem!=0: digit <= sel(rem), stay in OFFER. Back-to-back service, one index per cycle.
    - rem==0: valid <= 0, go to IDLE.
  - rem excludes same-cycle vector bits; those become visible on the next evaluation.
- ready while valid=0 is ignored.
- vector=0 with pending=0: block stays idle; no output change.
- Reset mid-OFFER: valid drops asynchronously; all pending events are discarded.
- Index range: digit is always < WIDTH.

Optional Feature:
- Macro ENCODER_ROUND_ROBIN_EN.
- Defined:
  - sel(mask) searches from (ptr+1) mod WIDTH upward, wrapping, and takes the first set bit.
  - ptr <= digit on every handshake.
  - Because ptr resets to WIDTH-1, the first search after reset starts at index 0.
- Undefined: fixed lowest-index priority; no pointer register.
- Ports, latency and handshake are identical in both builds.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> digit=0, valid=0, pending=0, overflow=0 immediately, without waiting for a clk edge.
- Single event: vector=8'h20 for 1 cycle at edge 0 with ready=1.
  - After edge 0: pending=8'h20.
  - After edge 1: valid=1, digit=5.
  - After edge 2: valid=0, pending=0.
- Burst: vector=8'h91 for 1 cycle, ready held 1 -> digit=0,4,7 on three consecutive valid cycles, then valid=0, overflow=0.
- Backpressure/overflow:
  - vector=8'h08, ready=0 -> valid=1, digit=3, held stable for 5 cycles.
  - Pulse vector=8'h08 again -> overflow=1 and stays 1.
  - Set ready=1 -> one handshake, then valid=0.
- Same-cycle re-post: while digit=2 is offered, drive vector=8'h04 in the handshake cycle -> pending[2] stays 1, overflow stays 0, and digit=2 is offered again.
- Priority mode:
  - vector=8'h06 pulse, serve 1 then 2 (ready=1).
  - Then vector=8'h09 pulse.
  - With ENCODER_ROUND_ROBIN_EN: digit order 3, 0.
  - Without it: digit order 0, 3.

Source files
------------

// File: rtl/vector_encoder.sv
// ----------------------------------------------------------------------------
// vector_encoder
//   Sequential 8-to-3 encoder. One-cycle event pulses on `vector` are collected
//   into a sticky pending mask, and the pending bits are then served one at a
//   time. The index of the bit being served is offered on `digit` under a
//   valid/ready handshake.
//
//   Optional build macro: ENCODER_ROUND_ROBIN_EN
//     undefined : fixed priority, lowest pending index is served first
//     defined   : round-robin, the search starts just above the last index served
//
// Ports
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   vector   in   [WIDTH] request bits, one event per high cycle
//   digit    out  [DW]    index currently offered
//   valid    out          digit is offered
//   ready    in           consumer accepts digit when ready & valid
//   pending  out  [WIDTH] registered pending-request mask
//   overflow out          sticky: event posted to an already-pending bit
// ----------------------------------------------------------------------------
module vector_encoder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] vector,
    output logic [DW-1:0]    digit,
    output logic             valid,
    input  logic             ready,
    output logic [WIDTH-1:0] pending,
    output logic             overflow
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [DW-1:0]    digit_q, digit_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             overflow_q, overflow_d;

    logic             hs_c;
    logic [WIDTH-1:0] cur_oh_c;
    logic [WIDTH-1:0] clr_c;
    logic [WIDTH-1:0] rem_c;
    logic [DW-1:0]    sel_idle_c;
    logic [DW-1:0]    sel_rem_c;

`ifdef ENCODER_ROUND_ROBIN_EN
    logic [DW-1:0]    ptr_q, ptr_d;

    // First set bit at or above (base+1), wrapping around WIDTH.
    function automatic logic [DW-1:0] sel(input logic [WIDTH-1:0] mask,
                                          input logic [DW-1:0]    base);
        logic        found;
        int unsigned idx;
        sel   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            idx = (32'(base) + 32'd1 + k) % WIDTH;
            if (!found && mask[DW'(idx)]) begin
                sel   = DW'(idx);
                found = 1'b1;
            end
        end
    endfunction

    // Idle search continues from the last served index; on a handshake the
    // pointer is about to become digit_q, so search from there directly.
    assign sel_idle_c = sel(pending_q, ptr_q);
    assign sel_rem_c  = sel(rem_c, digit_q);
    assign ptr_d      = hs_c ? digit_q : ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= DW'(WIDTH - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Lowest set index wins; scanning downward leaves the lowest one last.
    function automatic logic [DW-1:0] sel(input logic [WIDTH-1:0] mask);
        sel = '0;
        for (int k = int'(WIDTH) - 1; k >= 0; k--) begin
            if (mask[DW'(k)]) begin
                sel = DW'(k);
            end
        end
    endfunction

    assign sel_idle_c = sel(pending_q);
    assign sel_rem_c  = sel(rem_c);
`endif

    // Handshake clears the served bit; a same-cycle repost keeps it set
    // without counting as an overflow.
    assign hs_c       = valid_q & ready;
    assign cur_oh_c   = WIDTH'(1) << digit_q;
    assign clr_c      = hs_c ? cur_oh_c : '0;
    assign rem_c      = pending_q & ~cur_oh_c;
    assign pending_d  = (pending_q & ~clr_c) | vector;
    assign overflow_d = overflow_q | (|(vector & pending_q & ~clr_c));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (|pending_q)          state_d = OFFER;
            OFFER: if (ready && !(|rem_c))  state_d = IDLE;
        endcase
    end

    // Next values of the registered handshake outputs.
    always_comb begin
        digit_d = digit_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    digit_d = sel_idle_c;
                    valid_d = 1'b1;
                end
            end
            OFFER: begin
                if (ready) begin
                    if (|rem_c) begin
                        digit_d = sel_rem_c;
                    end else begin
                        valid_d = 1'b0;
                    end
                end
            end
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q    <= '0;
            valid_q    <= 1'b0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            digit_q    <= digit_d;
            valid_q    <= valid_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign digit    = digit_q;
    assign valid    = valid_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule
